hp_controller: RTL and testbench

//   Owns the soul's HP. Arbitrates damage requests from up to NUM_SRC hazard

---
 rtl/hp_if.sv | 26 ++
 rtl/hp_controller.sv | 153 +++++++++++++++
 tb/tb_hp_controller.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/hp_if.sv
// Damage/heal request bus between the hazard sources and the HP controller.
interface hp_if #(
  parameter int NUM_SRC = 4,
  parameter int DMG_W   = 4,
  parameter int HP_W    = 5
);
  logic [NUM_SRC-1:0]       dmg_req_in;
  logic [NUM_SRC*DMG_W-1:0] dmg_amt_in;
  logic                     heal_valid_in;
  logic [HP_W-1:0]          heal_amt_in;
  logic [NUM_SRC-1:0]       dmg_ack_out;
  logic [HP_W-1:0]          hp_out;
  logic                     hit_pulse_out;
  logic                     invuln_out;
  logic                     dead_out;

  modport master (
    output dmg_req_in, dmg_amt_in, heal_valid_in, heal_amt_in,
    input  dmg_ack_out, hp_out, hit_pulse_out, invuln_out, dead_out
  );

  modport slave (
    input  dmg_req_in, dmg_amt_in, heal_valid_in, heal_amt_in,
    output dmg_ack_out, hp_out, hit_pulse_out, invuln_out, dead_out
  );
endinterface

// File: rtl/hp_controller.sv
// Soul HP owner: round-robin damage arbitration, heals, i-frames, death flag.
module hp_controller #(
  parameter int MAX_HP        = 20,
  parameter int HP_W          = 5,
  parameter int NUM_SRC       = 4,
  parameter int DMG_W         = 4,
  parameter int IFRAME_CYCLES = 1_000_000
) (
  input logic clk,
  input logic rst,
  hp_if.slave bus
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(IFRAME_CYCLES);
  localparam int NW    = HP_W + 2;
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(IFRAME_CYCLES - 1);
  localparam logic [HP_W-1:0]      HP_FULL  = HP_W'(MAX_HP);
  localparam logic signed [NW-1:0] MAX_NW   = NW'(MAX_HP);

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

  state_t               state_q, state_d;
  logic [HP_W-1:0]      hp_q, hp_d;
  logic [NUM_SRC-1:0]   ack_q, ack_d, elig;
  logic                 hit_q, hit_d;
  logic                 invuln_q, invuln_d;
  logic                 dead_q, dead_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     rr_q, rr_d, win, probe;
  logic                 found;
  logic [DMG_W-1:0]     amt_arr [NUM_SRC];
  logic [DMG_W-1:0]     win_amt;
  logic                 win_hits;
  logic [NW-1:0]        heal_ext, dmg_ext;
  logic signed [NW-1:0] healed, net;
  logic                 net_le0;
  logic [HP_W-1:0]      net_sat, heal_sat;

  // A source whose ack is showing this cycle is already consumed.
  assign elig = bus.dmg_req_in & ~ack_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign amt_arr[g] = bus.dmg_amt_in[g*DMG_W +: DMG_W];
  end

  // Round-robin search: first eligible source at or above the rr pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    probe = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      probe = IDX_W'((32'(rr_q) + i) % NUM_SRC);
      if (!found && elig[probe]) begin
        found = 1'b1;
        win   = probe;
      end
    end
  end

  assign win_amt  = amt_arr[win];
  assign win_hits = found && (win_amt != '0);

  // Net HP arithmetic in a widened signed domain so nothing wraps.
  always_comb begin
    heal_ext = bus.heal_valid_in ? NW'(bus.heal_amt_in) : '0;
    dmg_ext  = found ? NW'(win_amt) : '0;
    healed   = signed'(NW'(hp_q) + heal_ext);
    net      = healed - signed'(dmg_ext);
    net_le0  = net[NW-1] || (net == '0);
    if (net_le0)
      net_sat = '0;
    else if (net >= MAX_NW)
      net_sat = HP_FULL;
    else
      net_sat = net[HP_W-1:0];
    heal_sat = (healed >= MAX_NW) ? HP_FULL : healed[HP_W-1:0];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALIVE:   if (win_hits) state_d = net_le0 ? DEAD : INVULN;
      INVULN:  if (cnt_q == '0) state_d = ALIVE;
      DEAD:    state_d = DEAD;
      default: state_d = ALIVE;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    ack_d = '0;
    hp_d  = hp_q;
    hit_d = 1'b0;
    cnt_d = cnt_q;
    rr_d  = rr_q;
    case (state_q)
      ALIVE: begin
        // With no grant dmg_ext is zero, so net_sat is the plain heal result.
        hp_d = net_sat;
        if (found) begin
          ack_d[win] = 1'b1;
          rr_d       = (32'(win) == NUM_SRC - 1) ? '0 : win + 1'b1;
        end
        if (win_hits) begin
          hit_d = 1'b1;
          cnt_d = CNT_LOAD;
        end
      end
      INVULN: begin
        ack_d = elig;
        if (bus.heal_valid_in) hp_d = heal_sat;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      DEAD: begin
        ack_d = elig;
        hp_d  = '0;
      end
      default: ;
    endcase
    invuln_d = (state_d == INVULN);
    dead_d   = (state_d == DEAD);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ALIVE;
      hp_q     <= HP_FULL;
      ack_q    <= '0;
      hit_q    <= 1'b0;
      invuln_q <= 1'b0;
      dead_q   <= 1'b0;
      cnt_q    <= '0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      hp_q     <= hp_d;
      ack_q    <= ack_d;
      hit_q    <= hit_d;
      invuln_q <= invuln_d;
      dead_q   <= dead_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
    end
  end

  assign bus.dmg_ack_out   = ack_q;
  assign bus.hp_out        = hp_q;
  assign bus.hit_pulse_out = hit_q;
  assign bus.invuln_out    = invuln_q;
  assign bus.dead_out      = dead_q;
endmodule

// File: tb/tb_hp_controller.sv
// Self-checking bench for hp_controller: directed scenarios plus random traffic
// against an integer-level reference model.
module tb_hp_controller;
  localparam int MAX_HP  = 20;
  localparam int HP_W    = 5;
  localparam int NUM_SRC = 4;
  localparam int DMG_W   = 4;
  localparam int IFRAME  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hp_if #(.NUM_SRC(NUM_SRC), .DMG_W(DMG_W), .HP_W(HP_W)) bus ();

  hp_controller #(
    .MAX_HP(MAX_HP), .HP_W(HP_W), .NUM_SRC(NUM_SRC),
    .DMG_W(DMG_W), .IFRAME_CYCLES(IFRAME)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus state (what the sources and the healer are doing).
  logic [NUM_SRC-1:0] req;
  int                 amt [NUM_SRC];
  logic               heal_v;
  int                 heal_a;

  // Reference model: HP as an integer, remaining i-frame cycles, rr pointer.
  int                 m_hp;
  bit                 m_dead;
  int                 m_left;
  int                 m_rr;
  bit [NUM_SRC-1:0]   m_ack;
  bit                 m_hit;

  task automatic model_step();
    bit [NUM_SRC-1:0] elig;
    int w;
    int v;
    elig  = req & ~m_ack;
    m_hit = 1'b0;
    if (rst) begin
      m_hp = MAX_HP; m_dead = 1'b0; m_left = 0; m_rr = 0; m_ack = '0;
      return;
    end
    if (m_dead) begin
      m_ack = elig;
      return;
    end
    if (m_left > 0) begin
      m_ack = elig;
      if (heal_v) m_hp = (m_hp + heal_a > MAX_HP) ? MAX_HP : m_hp + heal_a;
      m_left--;
      return;
    end
    m_ack = '0;
    w = -1;
    for (int k = 0; k < NUM_SRC; k++)
      if (w < 0 && elig[(m_rr + k) % NUM_SRC]) w = (m_rr + k) % NUM_SRC;
    v = m_hp + (heal_v ? heal_a : 0);
    if (w >= 0) begin
      m_ack[w] = 1'b1;
      m_rr     = (w + 1) % NUM_SRC;
      v        = v - amt[w];
      if (amt[w] != 0) begin
        m_hit = 1'b1;
        if (v <= 0) m_dead = 1'b1;
        else        m_left = IFRAME;
      end
    end
    m_hp = (v < 0) ? 0 : (v > MAX_HP) ? MAX_HP : v;
  endtask

  task automatic step_cycle();
    bus.dmg_req_in = req;
    for (int k = 0; k < NUM_SRC; k++)
      bus.dmg_amt_in[k*DMG_W +: DMG_W] = DMG_W'(amt[k]);
    bus.heal_valid_in = heal_v;
    bus.heal_amt_in   = HP_W'(heal_a);
    @(posedge clk);
    model_step();
    #1;
    check("hp",     int'(bus.hp_out),        m_dead ? 0 : m_hp);
    check("ack",    int'(bus.dmg_ack_out),   int'(m_ack));
    check("hit",    int'(bus.hit_pulse_out), int'(m_hit));
    check("invuln", int'(bus.invuln_out),    int'(m_left > 0));
    check("dead",   int'(bus.dead_out),      int'(m_dead));
    req    = req & ~m_ack;
    heal_v = 1'b0;
  endtask

  task automatic raise(input int s, input int a);
    req[s] = 1'b1;
    amt[s] = a;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_left > 0 || req != '0) && n < 100) begin
      step_cycle();
      n++;
    end
    check("wait_bound", int'(n < 100), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_cycle();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; req = '0; heal_v = 1'b0; heal_a = 0;
    for (int k = 0; k < NUM_SRC; k++) amt[k] = 0;
    m_hp = MAX_HP; m_dead = 1'b0; m_left = 0; m_rr = 0; m_ack = '0; m_hit = 1'b0;

    // 1: reset state, single hit, i-frame length
    step_cycle();
    check("rst_hp", int'(bus.hp_out), 20);
    check("rst_dead", int'(bus.dead_out), 0);
    rst = 1'b0;
    raise(0, 3);
    step_cycle();
    check("t1_hp", int'(bus.hp_out), 17);
    check("t1_ack", int'(bus.dmg_ack_out), 1);
    check("t1_hit", int'(bus.hit_pulse_out), 1);
    cnt = int'(bus.invuln_out);
    for (int n = 0; n < 40 && bus.invuln_out; n++) begin
      step_cycle();
      if (bus.invuln_out) cnt++;
    end
    check("t1_iframe_len", cnt, 16);

    // 2: three simultaneous requests, rr=0
    do_reset();
    raise(0, 2); raise(1, 5); raise(2, 6);
    step_cycle();
    check("t2_ack0", int'(bus.dmg_ack_out), 4'b0001);
    step_cycle();
    check("t2_ack12", int'(bus.dmg_ack_out), 4'b0110);
    wait_idle();
    check("t2_hp", int'(bus.hp_out), 18);

    // 3: round-robin after src2 wins
    raise(2, 1);
    step_cycle();
    wait_idle();
    raise(0, 4); raise(3, 1);
    step_cycle();
    check("t3_rr", int'(bus.dmg_ack_out), 4'b1000);
    wait_idle();
    check("t3_hp", int'(bus.hp_out), 16);

    // 4: death and stickiness
    raise(0, 14);
    step_cycle();
    wait_idle();
    check("t4_hp2", int'(bus.hp_out), 2);
    raise(1, 5);
    step_cycle();
    check("t4_hp0", int'(bus.hp_out), 0);
    check("t4_dead", int'(bus.dead_out), 1);
    check("t4_inv", int'(bus.invuln_out), 0);
    for (int n = 0; n < 3; n++) begin
      raise(n, 7); heal_v = 1'b1; heal_a = 10;
      step_cycle();
    end
    step_cycle();
    check("t4_heal_ign", int'(bus.hp_out), 0);
    do_reset();
    check("t4_rst_hp", int'(bus.hp_out), 20);
    check("t4_rst_dead", int'(bus.dead_out), 0);

    // 5: heal saturation, simultaneous heal and damage
    raise(0, 1);
    step_cycle();
    wait_idle();
    heal_v = 1'b1; heal_a = 7;
    step_cycle();
    check("t5_heal_sat", int'(bus.hp_out), 20);
    raise(1, 10);
    step_cycle();
    wait_idle();
    raise(2, 4); heal_v = 1'b1; heal_a = 3;
    step_cycle();
    check("t5_net", int'(bus.hp_out), 9);
    check("t5_hit", int'(bus.hit_pulse_out), 1);
    wait_idle();

    // 6: zero-damage request, reset mid-i-frame
    raise(3, 0);
    step_cycle();
    check("t6_zero_ack", int'(bus.dmg_ack_out), 4'b1000);
    check("t6_zero_hit", int'(bus.hit_pulse_out), 0);
    check("t6_zero_inv", int'(bus.invuln_out), 0);
    check("t6_zero_hp", int'(bus.hp_out), 9);
    raise(0, 2);
    step_cycle();
    step_cycle();
    step_cycle();
    raise(1, 3);
    do_reset();
    check("t6_rst_inv", int'(bus.invuln_out), 0);
    check("t6_rst_ack", int'(bus.dmg_ack_out), 0);
    req = '0;

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < NUM_SRC; k++)
        if (!req[k] && !m_ack[k] && $urandom_range(0, 3) == 0)
          raise(k, ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15)));
      heal_v = ($urandom_range(0, 7) == 0);
      heal_a = int'($urandom_range(0, 31));
      rst    = ($urandom_range(0, 199) == 0) || (m_dead && $urandom_range(0, 9) == 0);
      step_cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
